apb_master_arb: RTL and testbench

- Two-requester APB master that shares one APB bus to a single slave, such as the on-chip APB memory.
- Arbitrates local command requests round-robin and sequences the standard IDLE/SETUP/ACCESS APB protocol.
- Returns read data, completion and error status to the owning requester.
- Bounds slave wait states with a timeout counter so a stuck slave cannot hang the bus.

---
 rtl/apb_master_arb_if.sv | 57 +++++
 rtl/apb_master_arb.sv | 187 ++++++++++++++++++
 tb/tb_apb_master_arb.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arb_if.sv
// ---------------------------------------------------------------------------
// apb_master_arb_if
//   Bundles the two requester command/response channels and the APB bus of
//   apb_master_arb.
//   master modport : view of the arbiter (drives gnt/done/rdata/err and the
//                    APB control signals; receives requests, pready, prdata).
//   slave modport  : view of the environment (requesters plus APB slave).
// ---------------------------------------------------------------------------
interface apb_master_arb_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  // requester 0
  logic                  r0_req;
  logic                  r0_write;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_gnt;
  logic                  r0_done;
  logic [DATA_WIDTH-1:0] r0_rdata;
  logic                  r0_err;
  // requester 1
  logic                  r1_req;
  logic                  r1_write;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_gnt;
  logic                  r1_done;
  logic [DATA_WIDTH-1:0] r1_rdata;
  logic                  r1_err;
  // APB bus
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    input  r0_req, r0_write, r0_addr, r0_wdata,
    input  r1_req, r1_write, r1_addr, r1_wdata,
    output r0_gnt, r0_done, r0_rdata, r0_err,
    output r1_gnt, r1_done, r1_rdata, r1_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata
  );

  modport slave (
    output r0_req, r0_write, r0_addr, r0_wdata,
    output r1_req, r1_write, r1_addr, r1_wdata,
    input  r0_gnt, r0_done, r0_rdata, r0_err,
    input  r1_gnt, r1_done, r1_rdata, r1_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata
  );
endinterface

// File: rtl/apb_master_arb.sv
// ---------------------------------------------------------------------------
// apb_master_arb
//   Two-requester APB master. Requests are arbitrated round-robin and the
//   winning command is run through the IDLE/SETUP/ACCESS APB sequence. The
//   owner gets a one-cycle done pulse with read data and an error flag. A
//   wait-state counter aborts a transfer whose slave never raises pready.
//   Ports:
//     pclk    : clock
//     presetn : asynchronous active-low reset
//     bus     : requester channels and APB bus (master modport)
// ---------------------------------------------------------------------------
module apb_master_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16   // max ACCESS cycles; 0 disables the abort
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_master_arb_if.master   bus
);

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  last_q,    last_d;
  logic                  owner_q,   owner_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic                  done0_q,   done0_d;
  logic                  done1_q,   done1_d;
  logic                  err0_q,    err0_d;
  logic                  err1_q,    err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q,  rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q,  rdata1_d;

  // Arbitration
  logic                  access_ok;
  logic                  access_abort;
  logic                  grant;
  logic                  winner;
  logic [DATA_WIDTH-1:0] xfer_rdata;

  always_comb begin
    access_ok    = (state_q == ST_ACCESS) && bus.pready;
    access_abort = (state_q == ST_ACCESS) && !bus.pready && TO_EN && (cnt_q == CNT_LAST);
    // Both requesting: the one that did not go last wins. last_q resets to 1
    // so requester 0 wins the first tie.
    winner       = (bus.r0_req && bus.r1_req) ? ~last_q : bus.r1_req;
    // Gated by presetn so no grant is visible while the block is held in reset.
    grant        = presetn && (bus.r0_req || bus.r1_req) &&
                   ((state_q == ST_IDLE) || access_ok);
    xfer_rdata   = pwrite_q ? '0 : bus.prdata;
  end

  assign bus.r0_gnt = grant && !winner;
  assign bus.r1_gnt = grant &&  winner;

  // Next state and outputs
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = '0;
    rdata1_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        if (bus.pready) begin
          // pready has priority over a timeout landing on the same cycle.
          if (owner_q) begin
            done1_d  = 1'b1;
            rdata1_d = xfer_rdata;
          end else begin
            done0_d  = 1'b1;
            rdata0_d = xfer_rdata;
          end
          state_d = grant ? ST_SETUP : ST_IDLE;
        end else if (access_abort) begin
          if (owner_q) begin
            done1_d = 1'b1;
            err1_d  = 1'b1;
          end else begin
            done0_d = 1'b1;
            err0_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Latch the winner's command at any arbitration point.
    if (grant) begin
      owner_d  = winner;
      last_d   = winner;
      pwrite_d = winner ? bus.r1_write : bus.r0_write;
      paddr_d  = winner ? bus.r1_addr  : bus.r0_addr;
      pwdata_d = winner ? bus.r1_wdata : bus.r0_wdata;
    end

    // APB control follows the state being entered, so it is registered.
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.psel     = psel_q;
  assign bus.penable  = penable_q;
  assign bus.pwrite   = pwrite_q;
  assign bus.paddr    = paddr_q;
  assign bus.pwdata   = pwdata_q;
  assign bus.r0_done  = done0_q;
  assign bus.r1_done  = done1_q;
  assign bus.r0_err   = err0_q;
  assign bus.r1_err   = err1_q;
  assign bus.r0_rdata = rdata0_q;
  assign bus.r1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arb
//   Directed scenarios for reset, single transfers, back-to-back round-robin,
//   timeout and mid-transfer reset, followed by a randomized phase in which
//   two requester processes, an APB slave model and a done-pulse monitor run
//   concurrently against an expectation queue.
// ---------------------------------------------------------------------------
module tb_apb_master_arb;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    bit            id;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } exp_t;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;

  apb_master_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  bit   mon_en   = 1'b0;
  bit   slave_en = 1'b0;
  bit   last_m   = 1'b1;
  cmd_t cmd_q[$];
  exp_t exp0_q[$];
  exp_t exp1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return {~a, a, 8'h5A};
  endfunction

  task automatic idle_inputs();
    bus.r0_req = 1'b0; bus.r0_write = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_write = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
    bus.pready = 1'b0; bus.prdata = '0;
  endtask

  task automatic set_req(input bit id, input logic req, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id) begin
      bus.r1_req = req; bus.r1_write = wr; bus.r1_addr = a; bus.r1_wdata = d;
    end else begin
      bus.r0_req = req; bus.r0_write = wr; bus.r0_addr = a; bus.r0_wdata = d;
    end
  endtask

  task automatic drop_req(input bit id);
    if (id) bus.r1_req = 1'b0;
    else    bus.r0_req = 1'b0;
  endtask

  function automatic logic get_gnt(input bit id);
    return id ? bus.r1_gnt : bus.r0_gnt;
  endfunction

  // Random requester: issues n accepted commands, sometimes withdrawing a
  // request before it is granted.
  task automatic r_proc(input bit id, input int n);
    int accepted = 0;
    while (accepted < n) begin
      repeat ($urandom_range(0, 3)) tick();
      set_req(id, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      forever begin
        @(negedge pclk);
        if (get_gnt(id)) begin
          tick();
          drop_req(id);
          accepted++;
          break;
        end
        tick();
        if ($urandom_range(0, 15) == 0) begin
          drop_req(id);
          break;
        end
      end
    end
  endtask

  // Acceptance observer: reference round-robin and command capture.
  always @(negedge pclk) begin
    if (mon_en && (bus.r0_gnt || bus.r1_gnt)) begin
      cmd_t c;
      bit   exp_w;
      check("gnt_one_hot", {bus.r0_gnt, bus.r1_gnt}, bus.r1_gnt ? 32'd1 : 32'd2);
      check("gnt_needs_req", (bus.r0_gnt && !bus.r0_req) || (bus.r1_gnt && !bus.r1_req), 0);
      check("gnt_at_arb_point", !bus.psel || (bus.penable && bus.pready), 1);
      exp_w = (bus.r0_req && bus.r1_req) ? !last_m : bus.r1_req;
      check("arb_winner", bus.r1_gnt, exp_w);
      last_m = bus.r1_gnt;
      c.id    = bus.r1_gnt;
      c.write = bus.r1_gnt ? bus.r1_write : bus.r0_write;
      c.addr  = bus.r1_gnt ? bus.r1_addr  : bus.r0_addr;
      c.wdata = bus.r1_gnt ? bus.r1_wdata : bus.r0_wdata;
      cmd_q.push_back(c);
    end
  end

  // APB slave model: picks a wait count per transfer and derives the
  // expected response and completion cycle from it.
  int            sl_w = 0;
  int            sl_k = 0;
  logic [AW-1:0] sl_addr = '0;
  always @(posedge pclk) begin
    #1;
    if (slave_en) begin
      if (bus.psel && !bus.penable) begin
        if (cmd_q.size() == 0) begin
          check("setup_has_cmd", 0, 1);
        end else begin
          cmd_t c;
          exp_t e;
          int   n;
          c = cmd_q.pop_front();
          check("paddr", bus.paddr, c.addr);
          check("pwrite", bus.pwrite, c.write);
          if (c.write) check("pwdata", bus.pwdata, c.wdata);
          sl_w    = ($urandom_range(0, 7) == 0) ? TO - 1 + $urandom_range(0, 2)
                                                : $urandom_range(0, 2);
          sl_k    = 0;
          sl_addr = c.addr;
          e.err   = (sl_w >= TO);
          e.rdata = (e.err || c.write) ? '0 : slave_data(c.addr);
          n       = e.err ? TO : sl_w + 1;
          e.due   = cyc + n + 1;
          if (c.id) exp1_q.push_back(e);
          else      exp0_q.push_back(e);
        end
        bus.pready = 1'($urandom_range(0, 1));
        bus.prdata = DW'($urandom);
      end else if (bus.psel && bus.penable) begin
        bus.pready = (sl_k == sl_w);
        bus.prdata = (sl_k == sl_w) ? slave_data(sl_addr) : DW'($urandom);
        sl_k++;
      end else begin
        bus.pready = 1'($urandom_range(0, 1));
        bus.prdata = DW'($urandom);
      end
    end
  end

  // Completion monitor.
  always @(negedge pclk) begin
    if (mon_en && (bus.r0_done || bus.r1_done)) begin
      exp_t e;
      check("done_one_hot", bus.r0_done && bus.r1_done, 0);
      if (bus.r0_done) begin
        if (exp0_q.size() == 0) check("r0_done_expected", 0, 1);
        else begin
          e = exp0_q.pop_front();
          check("r0_rdata", bus.r0_rdata, e.rdata);
          check("r0_err", bus.r0_err, e.err);
          check("r0_done_cycle", cyc, e.due);
        end
      end
      if (bus.r1_done) begin
        if (exp1_q.size() == 0) check("r1_done_expected", 0, 1);
        else begin
          e = exp1_q.pop_front();
          check("r1_rdata", bus.r1_rdata, e.rdata);
          check("r1_err", bus.r1_err, e.err);
          check("r1_done_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    int  gq[$];
    int  dq[$];
    int  n0, n1, nacc;
    bit  a0, a1, psel_drop, seen, timed_out;

    idle_inputs();

    // ---- reset with random inputs ----
    presetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.r0_req = 1'($urandom); bus.r1_req = 1'($urandom);
      bus.r0_write = 1'($urandom); bus.r1_write = 1'($urandom);
      bus.r0_addr = AW'($urandom); bus.r1_addr = AW'($urandom);
      bus.pready = 1'($urandom); bus.prdata = DW'($urandom);
      #3;
      check("rst_psel", bus.psel, 0);
      check("rst_penable", bus.penable, 0);
      check("rst_gnt", {bus.r0_gnt, bus.r1_gnt}, 0);
      check("rst_done_err", {bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err}, 0);
      check("rst_paddr", bus.paddr, 0);
    end
    idle_inputs();
    tick();
    presetn = 1'b1;
    psel_drop = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      if (bus.psel) psel_drop = 1'b1;
      tick();
    end
    check("idle_no_req", psel_drop, 0);

    // ---- r0 write, zero wait states ----
    set_req(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
    bus.pready = 1'b1;
    @(negedge pclk);
    check("w_c0_r0_gnt", bus.r0_gnt, 1);
    check("w_c0_r1_gnt", bus.r1_gnt, 0);
    check("w_c0_psel", bus.psel, 0);
    tick(); drop_req(0);
    @(negedge pclk);
    check("w_c1_setup", {bus.psel, bus.penable}, 2'b10);
    tick();
    @(negedge pclk);
    check("w_c2_access", {bus.psel, bus.penable, bus.pwrite}, 3'b111);
    check("w_c2_paddr", bus.paddr, 12'h010);
    check("w_c2_pwdata", bus.pwdata, 32'hDEADBEEF);
    tick();
    @(negedge pclk);
    check("w_c3_done", {bus.r0_done, bus.r0_err, bus.r1_done}, 3'b100);
    check("w_c3_rdata", bus.r0_rdata, 0);
    check("w_c3_psel", bus.psel, 0);
    tick();
    @(negedge pclk);
    check("w_c4_done_pulse", bus.r0_done, 0);

    // ---- r1 read with two wait states ----
    tick();
    set_req(1, 1'b1, 1'b0, 12'h3FF, 32'h0);
    bus.pready = 1'b0;
    @(negedge pclk);
    check("r_c0_r1_gnt", bus.r1_gnt, 1);
    tick(); drop_req(1);
    @(negedge pclk);
    check("r_c1_setup", {bus.psel, bus.penable}, 2'b10);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) begin bus.pready = 1'b1; bus.prdata = 32'h12345678; end
      @(negedge pclk);
      check("r_access", {bus.psel, bus.penable, bus.pwrite}, 3'b110);
      check("r_paddr_stable", bus.paddr, 12'h3FF);
    end
    tick();
    bus.pready = 1'b0;
    @(negedge pclk);
    check("r_c5_done", {bus.r1_done, bus.r1_err, bus.r0_done}, 3'b100);
    check("r_c5_rdata", bus.r1_rdata, 32'h12345678);
    check("r_c5_psel", bus.psel, 0);

    // ---- back-to-back round robin, 4 transfers each ----
    tick();
    set_req(0, 1'b1, 1'b1, 12'h100, 32'h0000_0100);
    set_req(1, 1'b1, 1'b1, 12'h200, 32'h0000_0200);
    bus.pready = 1'b1;
    n0 = 4; n1 = 4; psel_drop = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(negedge pclk);
      a0 = bus.r0_req && bus.r0_gnt;
      a1 = bus.r1_req && bus.r1_gnt;
      if (a0) gq.push_back(0);
      if (a1) gq.push_back(1);
      if (bus.r0_done || bus.r1_done) dq.push_back(c);
      if (c >= 1 && c <= 16 && !bus.psel) psel_drop = 1'b1;
      tick();
      if (a0) begin n0--; if (n0 == 0) drop_req(0); end
      if (a1) begin n1--; if (n1 == 0) drop_req(1); end
    end
    check("rr_grant_count", gq.size(), 8);
    for (int i = 0; i < gq.size() && i < 8; i++) check("rr_grant_order", gq[i], i % 2);
    check("rr_psel_held", psel_drop, 0);
    check("rr_done_count", dq.size(), 8);
    for (int i = 0; i < dq.size() && i < 8; i++) check("rr_done_cycle", dq[i], 3 + 2 * i);

    // ---- timeout abort, then success on the last allowed cycle ----
    for (int pass = 0; pass < 2; pass++) begin
      idle_inputs();
      tick();
      set_req(0, 1'b1, 1'b0, 12'h020, 32'h0);
      @(negedge pclk);
      check("to_gnt", bus.r0_gnt, 1);
      tick(); drop_req(0);
      nacc = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge pclk);
        if (bus.psel && bus.penable) begin
          nacc++;
          if (pass == 1 && nacc == TO) begin
            bus.pready = 1'b1;
            bus.prdata = 32'hCAFEF00D;
          end
        end
        if (bus.r0_done) begin
          seen = 1'b1;
          check("to_err", bus.r0_err, pass == 0);
          check("to_rdata", bus.r0_rdata, pass == 0 ? 32'h0 : 32'hCAFEF00D);
          check("to_psel", bus.psel, 0);
        end
        tick();
        bus.pready = 1'b0;
      end
      check("to_done_seen", seen, 1);
      check("to_access_cycles", nacc, TO);
    end

    // ---- reset during ACCESS of an r1 write ----
    idle_inputs();
    tick();
    set_req(1, 1'b1, 1'b1, 12'h055, 32'hA5A5A5A5);
    @(negedge pclk);
    check("rst_mid_gnt", bus.r1_gnt, 1);
    tick(); drop_req(1);
    tick();
    @(negedge pclk);
    check("rst_mid_access", {bus.psel, bus.penable}, 2'b11);
    #2;
    presetn = 1'b0;
    #1;
    check("rst_mid_ctrl", {bus.psel, bus.penable, bus.pwrite}, 0);
    check("rst_mid_paddr", bus.paddr, 0);
    check("rst_mid_pwdata", bus.pwdata, 0);
    seen = 1'b0;
    bus.pready = 1'b1;
    repeat (2) begin tick(); if (bus.r1_done) seen = 1'b1; end
    presetn = 1'b1;
    repeat (5) begin
      @(negedge pclk);
      if (bus.r1_done) seen = 1'b1;
      tick();
    end
    check("rst_mid_no_done", seen, 0);
    set_req(0, 1'b1, 1'b0, 12'h001, 32'h0);
    set_req(1, 1'b1, 1'b0, 12'h002, 32'h0);
    @(negedge pclk);
    check("rst_first_tie", {bus.r0_gnt, bus.r1_gnt}, 2'b10);
    tick();
    drop_req(0); drop_req(1);
    repeat (4) tick();

    // ---- randomized phase ----
    idle_inputs();
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    last_m   = 1'b1;
    mon_en   = 1'b1;
    slave_en = 1'b1;
    timed_out = 1'b0;
    fork
      begin
        fork
          r_proc(0, 40);
          r_proc(1, 40);
        join
        for (int c = 0; c < 200 && (cmd_q.size() != 0 || exp0_q.size() != 0 ||
                                    exp1_q.size() != 0); c++) tick();
        repeat (3) tick();
      end
      begin
        repeat (20000) @(posedge pclk);
        timed_out = 1'b1;
      end
    join_any
    disable fork;
    check("random_phase_complete", timed_out, 0);
    check("random_queues_drained", cmd_q.size() + exp0_q.size() + exp1_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
